// File: rtl/dbg_imem_reader_if.sv
// Signal bundle for the debug instruction-memory read-back engine: host burst
// request/stream side plus the instruction-memory read port.
interface dbg_imem_reader_if #(
  parameter int XLEN               = 64,
  parameter int INSTRUCTION_LENGTH = XLEN / 2,
  parameter int CNT_W              = 16
);
  logic                          dbg_rd_start;
  logic [XLEN-1:0]               dbg_rd_addr;
  logic [CNT_W-1:0]              dbg_rd_count;
  logic                          dbg_rd_busy;
  logic                          dbg_rd_done;
  logic                          dbg_rd_err;
  logic [INSTRUCTION_LENGTH-1:0] dbg_rd_data;
  logic                          dbg_rd_valid;
  logic                          dbg_rd_ready;
  logic                          imem_rd_en;
  logic [XLEN-1:0]               imem_rd_addr;
  logic [INSTRUCTION_LENGTH-1:0] imem_rd_data;

  // The reader engine itself.
  modport master (
    input  dbg_rd_start, dbg_rd_addr, dbg_rd_count, dbg_rd_ready, imem_rd_data,
    output dbg_rd_busy, dbg_rd_done, dbg_rd_err, dbg_rd_data, dbg_rd_valid,
           imem_rd_en, imem_rd_addr
  );

  // The host and the instruction memory together.
  modport slave (
    output dbg_rd_start, dbg_rd_addr, dbg_rd_count, dbg_rd_ready, imem_rd_data,
    input  dbg_rd_busy, dbg_rd_done, dbg_rd_err, dbg_rd_data, dbg_rd_valid,
           imem_rd_en, imem_rd_addr
  );
endinterface

// File: rtl/dbg_imem_reader.sv
// Debug read-back engine: streams a burst of instruction words out of the
// 1-cycle-latency instruction memory through a 2-entry buffer to the host.
module dbg_imem_reader #(
  parameter int XLEN               = 64,
  parameter int INSTRUCTION_LENGTH = XLEN / 2,
  parameter int CNT_W              = 16
) (
  input  logic              clk,
  input  logic              rst,
  dbg_imem_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                        state;
  logic [XLEN-1:0]               addr_q;
  logic [CNT_W-1:0]              remaining;
  logic                          inflight;
  logic [INSTRUCTION_LENGTH-1:0] buf_mem [2];
  logic                          rd_ptr;
  logic                          wr_ptr;
  logic [1:0]                    buf_count;
  logic                          busy_q;
  logic                          done_q;
  logic                          err_q;

  logic       pop;
  logic       issue;
  logic [2:0] occupancy;
  logic [1:0] count_next;

  // Words that will be held after this cycle's pop; a new read is only issued
  // when its returning word is guaranteed a free buffer slot.
  assign pop        = (buf_count != 2'd0) && bus.dbg_rd_ready;
  assign occupancy  = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
  assign count_next = buf_count + {1'b0, inflight} - {1'b0, pop};
  assign issue      = (state == RUN) && (occupancy < 3'd2);

  assign bus.imem_rd_en   = issue;
  assign bus.imem_rd_addr = addr_q;
  assign bus.dbg_rd_valid = (buf_count != 2'd0);
  assign bus.dbg_rd_data  = buf_mem[rd_ptr];
  assign bus.dbg_rd_busy  = busy_q;
  assign bus.dbg_rd_done  = done_q;
  assign bus.dbg_rd_err   = err_q;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, whatever the order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      remaining  <= '0;
      inflight   <= 1'b0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      buf_count  <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      // NOTE: the buffer entries are reset because the head drives
      // dbg_rd_data directly, which must read zero out of reset.
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
    end else begin
      done_q    <= 1'b0;
      inflight  <= issue;
      buf_count <= count_next;

      if (inflight) begin
        buf_mem[wr_ptr] <= bus.imem_rd_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      case (state)
        IDLE: begin
          if (bus.dbg_rd_start) begin
            if (bus.dbg_rd_addr[1:0] != 2'b00) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end else if (bus.dbg_rd_count == '0) begin
              err_q  <= 1'b0;
              done_q <= 1'b1;
            end else begin
              addr_q    <= bus.dbg_rd_addr;
              remaining <= bus.dbg_rd_count;
              err_q     <= 1'b0;
              busy_q    <= 1'b1;
              state     <= RUN;
            end
          end
        end

        RUN: begin
          if (issue) begin
            addr_q    <= addr_q + XLEN'(4);
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state <= DRAIN;
            end
          end
        end

        DRAIN: begin
          // Leave once the last word has been handed over and nothing is left.
          if (!inflight && (count_next == 2'd0)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
